// File: rtl/hopfield_pkg.sv
// Shared definitions for the Hopfield network slice: decoder FSM states and
// the default lane count.
package hopfield_pkg;

    localparam int N_NEURONS_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

endpackage

// File: rtl/spike_counter.sv
// Per-neuron spike accumulator for one decode window. The count output already
// includes the spike of the current cycle so the last window cycle is not lost.
module spike_counter
    import hopfield_pkg::*;
#(
    parameter int WINDOW_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 spike,
    output logic [WINDOW_LOG2:0] count
);

    localparam int CW = WINDOW_LOG2 + 1;

    logic [CW-1:0] count_q;

    // Accumulate spikes while enabled; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CW{1'b0}};
        end else if (clr) begin
            count_q <= {CW{1'b0}};
        end else if (en && spike) begin
            count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

    // Registered count can reach at most 2^WINDOW_LOG2-1 before the final
    // cycle, so adding the final spike still fits in CW bits.
    always_comb begin
        count = count_q + {{(CW-1){1'b0}}, spike};
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate-decodes the network spike vector into a binary pattern per window,
// offers it over valid/ready and flags convergence on repeated patterns.
module spike_rate_decoder
    import hopfield_pkg::*;
#(
    parameter int N_NEURONS      = N_NEURONS_DEF,
    parameter int WINDOW_LOG2    = 4,
    parameter int THRESH         = 8,
    parameter int STABLE_WINDOWS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [N_NEURONS-1:0] spikes,
    output logic [N_NEURONS-1:0] pattern,
    output logic                 pattern_valid,
    input  logic                 pattern_ready,
    output logic                 converged,
    output logic                 busy
);

    localparam int CW = WINDOW_LOG2 + 1;
    localparam int RW = $clog2(STABLE_WINDOWS + 1);
    localparam logic [CW-1:0]          THRESH_L = CW'(THRESH);
    localparam logic [RW-1:0]          RUN_MAX  = RW'(STABLE_WINDOWS);
    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = {WINDOW_LOG2{1'b1}};

    state_e                 state_q;
    logic [WINDOW_LOG2-1:0] win_q;
    logic [N_NEURONS-1:0]   pattern_q;
    logic [N_NEURONS-1:0]   prev_q;
    logic                   valid_q;
    logic                   conv_q;
    logic                   busy_q;
    logic [RW-1:0]          run_q;
    logic [RW-1:0]          run_d;

    logic                   cnt_clr_s;
    logic                   cnt_en_s;
    logic [CW-1:0]          count_s [N_NEURONS];
    logic [N_NEURONS-1:0]   hit_s;

    // Counters run only inside COUNT and restart on any exit from it.
    always_comb begin
        cnt_en_s = (state_q == ST_COUNT);
        if (clear || (state_q != ST_COUNT) || !enable || (win_q == WIN_LAST)) begin
            cnt_clr_s = 1'b1;
        end else begin
            cnt_clr_s = 1'b0;
        end
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_lane
        spike_counter #(
            .WINDOW_LOG2 (WINDOW_LOG2)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (cnt_clr_s),
            .en    (cnt_en_s),
            .spike (spikes[g]),
            .count (count_s[g])
        );
    end

    // Threshold compare on the spike-inclusive window totals.
    always_comb begin
        hit_s = {N_NEURONS{1'b0}};
        for (int i = 0; i < N_NEURONS; i++) begin
            hit_s[i] = (count_s[i] >= THRESH_L);
        end
    end

    // Run length of identical accepted patterns; zero means nothing accepted yet.
    always_comb begin
        if ((run_q != {RW{1'b0}}) && (pattern_q == prev_q)) begin
            if (run_q == RUN_MAX) begin
                run_d = run_q;
            end else begin
                run_d = run_q + {{(RW-1){1'b0}}, 1'b1};
            end
        end else begin
            run_d = {{(RW-1){1'b0}}, 1'b1};
        end
    end

    // Decoder FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            win_q     <= {WINDOW_LOG2{1'b0}};
            pattern_q <= {N_NEURONS{1'b0}};
            prev_q    <= {N_NEURONS{1'b0}};
            valid_q   <= 1'b0;
            conv_q    <= 1'b0;
            busy_q    <= 1'b0;
            run_q     <= {RW{1'b0}};
        end else if (clear) begin
            state_q   <= ST_IDLE;
            win_q     <= {WINDOW_LOG2{1'b0}};
            pattern_q <= {N_NEURONS{1'b0}};
            prev_q    <= {N_NEURONS{1'b0}};
            valid_q   <= 1'b0;
            conv_q    <= 1'b0;
            busy_q    <= 1'b0;
            run_q     <= {RW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    win_q <= {WINDOW_LOG2{1'b0}};
                    if (enable) begin
                        state_q <= ST_COUNT;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        win_q   <= {WINDOW_LOG2{1'b0}};
                    end else if (win_q == WIN_LAST) begin
                        state_q   <= ST_EMIT;
                        busy_q    <= 1'b1;
                        pattern_q <= hit_s;
                        valid_q   <= 1'b1;
                        win_q     <= {WINDOW_LOG2{1'b0}};
                    end else begin
                        win_q <= win_q + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
                    end
                end
                ST_EMIT: begin
                    // valid is always high here, so ready alone completes the handshake.
                    if (pattern_ready) begin
                        valid_q <= 1'b0;
                        run_q   <= run_d;
                        conv_q  <= (run_d >= RUN_MAX);
                        prev_q  <= pattern_q;
                        if (enable) begin
                            state_q <= ST_COUNT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_EMIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    win_q   <= {WINDOW_LOG2{1'b0}};
                end
            endcase
        end
    end

    assign pattern       = pattern_q;
    assign pattern_valid = valid_q;
    assign converged     = conv_q;
    assign busy          = busy_q;

endmodule
